even_up_count: RTL and testbench
================================

EVEN_UP_COUNT -- requirements
Module: even_up_count

Interface
REQ-001 SHALL have parameter: WIDTH, 8, counter width in bits.
REQ-002 SHALL have parameter: STEP, 2, increment per enabled cycle; SHALL be even and nonzero.
REQ-003 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: en  input  1  count enable, sampled each rising edge.
REQ-006 SHALL have port: start  input  1  one-cycle request to begin counting from 0.
REQ-007 SHALL have port: stop  input  1  one-cycle request to stop and hold the value.
REQ-008 SHALL have port: load  input  1  load load_val into out.
REQ-009 SHALL have port: load_val  input  WIDTH  load value; bit 0 ignored.
REQ-010 SHALL have port: limit  input  WIDTH  terminal value; bit 0 ignored.
REQ-011 SHALL have port: wrap_en  input  1  1 = restart at 0 after limit; 0 = halt at limit.
REQ-012 SHALL have port: out  output  WIDTH  count value; bit 0 always 0.
REQ-013 SHALL have port: busy  output  1  high while in RUN.
REQ-014 SHALL have port: tc  output  1  one-cycle pulse on terminal-count wrap.
REQ-015 SHALL have port: done  output  1  one-cycle pulse on entering HALT.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, HALT.
REQ-017 Effective limit SHALL be limit with bit 0 cleared; effective limit 0 SHALL mean terminal value 2^WIDTH-2 (8'hFE).
REQ-018 Priority each edge SHALL be rst > load > stop > start > count.
REQ-019 load SHALL set out to load_val with bit 0 cleared in any state, leave the state unchanged, and suppress counting that cycle.
REQ-020 start in IDLE or HALT SHALL set out to 0 and enter RUN; start in RUN SHALL restart out at 0.
REQ-021 stop in RUN SHALL enter IDLE with out held; stop in IDLE or HALT SHALL have no effect.
REQ-022 In RUN with en=1 and out != terminal, out SHALL become out+STEP modulo 2^WIDTH on the next edge, a latency of 1 cycle.
REQ-023 In RUN with en=1, out == terminal and wrap_en=1, out SHALL become 0, tc SHALL be high for the following cycle, and the state SHALL remain RUN.
REQ-024 In RUN with en=1, out == terminal and wrap_en=0, the state SHALL become HALT, out SHALL hold the terminal value, and done SHALL be high for the following cycle.
REQ-025 Arithmetic overflow past 2^WIDTH-2 with the terminal not reached (for example, after a load above limit) SHALL wrap to 0 without a tc pulse, and counting SHALL continue until the terminal is reached.
REQ-026 With en=0, out SHALL hold in every state; IDLE and HALT SHALL never count.
REQ-027 tc and done SHALL be registered, SHALL never be high simultaneously, and SHALL be 0 whenever not pulsing.
REQ-028 busy SHALL be a registered decode of state == RUN.
REQ-029 A change of limit while in RUN SHALL take effect on the next comparison.

Reset
REQ-030 rst=1 at a rising edge SHALL force state IDLE, out=0, busy=0, tc=0, done=0, overriding all other inputs.
REQ-031 Reset asserted in mid-count SHALL discard any pending tc or done pulse.

Structure
REQ-032 State encoding (IDLE=0, RUN=1, HALT=2) and the default WIDTH and STEP SHALL live in a shared package even_count_pkg.
REQ-033 The terminal-value compare SHALL be a sub-module even_term_cmp (inputs: out, limit; output: hit); all other logic SHALL reside in even_up_count.

Verification
REQ-034 The bench SHALL check: rst then start, en=1, limit=8, wrap_en=0 -> out 0,2,4,6,8; done pulse concurrent with the first cycle at 8 in HALT; busy=0 afterwards.
REQ-035 The bench SHALL check: limit=6, wrap_en=1, en=1 for 10 cycles -> out 0,2,4,6,0,2,4,6,0,2; tc high on each cycle where out returned to 0.
REQ-036 The bench SHALL check: load_val=8'hFB while in RUN with limit=4 -> out=FA, then FC, FE, 00 (no tc), 02, 04, then tc behaviour per wrap_en.
REQ-037 The bench SHALL check: load and start in the same cycle with load_val=0x11 -> out=0x10, state unchanged; a stop during RUN at out=0x20 -> out holds 0x20 and busy=0.
REQ-038 The bench SHALL check: limit=0, wrap_en=1 -> the count runs to FE, then 00 with a tc pulse.
REQ-039 The bench SHALL check: rst asserted on the cycle out reaches the terminal -> out=0, IDLE, no tc or done pulse afterwards.

Source files
------------

// File: rtl/even_count_pkg.sv
// Shared types and defaults for the even up-counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package even_count_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_STEP  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

endpackage

// File: rtl/even_term_cmp.sv
// Terminal-value compare: flags when the count equals the effective (even) limit.
// Latency: combinational.
// Backpressure: none.
module even_term_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] limit,
    output logic             hit
);

    logic [WIDTH-1:0] w_lim_even;
    logic [WIDTH-1:0] w_term;
    logic             w_unused_lim0;

    // Bit 0 of the limit is meaningless for an even counter.
    assign w_unused_lim0 = limit[0];
    assign w_lim_even    = {limit[WIDTH-1:1], 1'b0};

    // A zero limit means "run to the largest even value".
    assign w_term = (w_lim_even == '0) ? {{(WIDTH-1){1'b1}}, 1'b0} : w_lim_even;

    assign hit = (out == w_term);

endmodule

// File: rtl/even_up_count.sv
// Even up-counter with IDLE/RUN/HALT control, load, wrap or halt at terminal.
// Latency: 1 cycle from enabled edge to updated count and pulses.
// Backpressure: none; en gates counting, stop/start/load act immediately.
module even_up_count
    import even_count_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = DEF_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             wrap_en,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    // Increment forced even so the count can never acquire an odd bit.
    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP) & {{(WIDTH-1){1'b1}}, 1'b0};

    state_t           r_state;
    logic [WIDTH-1:0] r_out;
    logic             r_busy;
    logic             r_tc;
    logic             r_done;

    state_t           w_state_nx;
    logic [WIDTH-1:0] w_out_nx;
    logic             w_tc_nx;
    logic             w_done_nx;
    logic             w_hit;
    logic [WIDTH-1:0] w_inc;
    logic             w_unused_lv0;

    assign w_unused_lv0 = load_val[0];
    assign w_inc        = r_out + STEP_V;

    even_term_cmp #(
        .WIDTH (WIDTH)
    ) u_term_cmp (
        .out   (r_out),
        .limit (limit),
        .hit   (w_hit)
    );

    // Next state / next count, priority load > stop > start > count.
    always_comb begin
        w_state_nx = r_state;
        w_out_nx   = r_out;
        w_tc_nx    = 1'b0;
        w_done_nx  = 1'b0;
        if (load) begin
            w_out_nx = {load_val[WIDTH-1:1], 1'b0};
        end else if (stop) begin
            if (r_state == S_RUN) begin
                w_state_nx = S_IDLE;
            end
        end else if (start) begin
            w_out_nx   = '0;
            w_state_nx = S_RUN;
        end else if ((r_state == S_RUN) && en) begin
            if (w_hit) begin
                if (wrap_en) begin
                    w_out_nx = '0;
                    w_tc_nx  = 1'b1;
                end else begin
                    w_state_nx = S_HALT;
                    w_done_nx  = 1'b1;
                end
            end else begin
                // Overflow past the top wraps silently; only the terminal pulses tc.
                w_out_nx = w_inc;
            end
        end
    end

    // State, count and registered status outputs; reset drops any pending pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_tc    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_out   <= w_out_nx;
            r_busy  <= (w_state_nx == S_RUN);
            r_tc    <= w_tc_nx;
            r_done  <= w_done_nx;
        end
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign tc   = r_tc;
    assign done = r_done;

endmodule

// File: tb/tb_even_up_count.sv
// Directed table-driven bench for even_up_count plus corner-case sequences.
// Latency: expects outputs one edge after inputs are applied.
// Backpressure: n/a.
module tb_even_up_count;

    logic       clk = 1'b0;
    logic       rst, en, start, stop, load, wrap_en;
    logic [7:0] load_val, limit;
    logic [7:0] out;
    logic       busy, tc, done;

    int errors = 0;
    int checks = 0;

    even_up_count #(.WIDTH(8), .STEP(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .start    (start),
        .stop     (stop),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .wrap_en  (wrap_en),
        .out      (out),
        .busy     (busy),
        .tc       (tc),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, en, start, stop, load;
        logic [7:0] lv, lim;
        logic       wrap;
        logic [7:0] eo;
        logic       eb, et, ed;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic e, input logic st, input logic sp,
                       input logic ld, input logic [7:0] lv, input logic [7:0] lim,
                       input logic w, input logic [7:0] eo, input logic eb,
                       input logic et, input logic ed);
        vec_t v;
        v.rst = r; v.en = e; v.start = st; v.stop = sp; v.load = ld;
        v.lv = lv; v.lim = lim; v.wrap = w;
        v.eo = eo; v.eb = eb; v.et = et; v.ed = ed;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, then sample away from the edge.
    task automatic cyc(input logic r, input logic e, input logic st, input logic sp,
                       input logic ld, input logic [7:0] lv, input logic [7:0] lim,
                       input logic w);
        rst = r; en = e; start = st; stop = sp; load = ld;
        load_val = lv; limit = lim; wrap_en = w;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string nm, input int idx, input logic [7:0] eo,
                              input logic eb, input logic et, input logic ed);
        chk({nm, ".out"},  idx, out,         eo);
        chk({nm, ".busy"}, idx, {7'd0, busy}, {7'd0, eb});
        chk({nm, ".tc"},   idx, {7'd0, tc},   {7'd0, et});
        chk({nm, ".done"}, idx, {7'd0, done}, {7'd0, ed});
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
        load_val = '0; limit = '0; wrap_en = 1'b0;

        //   rst en st sp ld  lv     lim    w   out    b  t  d
        // count to 8 and halt
        add(1, 0, 0, 0, 0, 8'h00, 8'h08, 0, 8'h00, 0, 0, 0);
        add(0, 1, 1, 0, 0, 8'h00, 8'h08, 0, 8'h00, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h08, 0, 8'h02, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h08, 0, 8'h04, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h08, 0, 8'h06, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h08, 0, 8'h08, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h08, 0, 8'h08, 0, 0, 1);
        add(0, 1, 0, 0, 0, 8'h00, 8'h08, 0, 8'h08, 0, 0, 0);
        // wrap at 6 for ten samples
        add(0, 1, 1, 0, 0, 8'h00, 8'h06, 1, 8'h00, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h06, 1, 8'h02, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h06, 1, 8'h04, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h06, 1, 8'h06, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h06, 1, 8'h00, 1, 1, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h06, 1, 8'h02, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h06, 1, 8'h04, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h06, 1, 8'h06, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h06, 1, 8'h00, 1, 1, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h06, 1, 8'h02, 1, 0, 0);
        // load above limit: silent overflow, then wrap, then halt
        add(0, 1, 0, 0, 1, 8'hFB, 8'h04, 1, 8'hFA, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h04, 1, 8'hFC, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h04, 1, 8'hFE, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h04, 1, 8'h00, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h04, 1, 8'h02, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h04, 1, 8'h04, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h04, 1, 8'h00, 1, 1, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h04, 0, 8'h02, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h04, 0, 8'h04, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h04, 0, 8'h04, 0, 0, 1);
        // load beats start; HALT is kept and never counts
        add(0, 1, 1, 0, 1, 8'h11, 8'h04, 0, 8'h10, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h04, 0, 8'h10, 0, 0, 0);
        // stop during RUN at 0x20
        add(0, 1, 1, 0, 0, 8'h00, 8'h40, 0, 8'h00, 1, 0, 0);
        add(0, 1, 0, 0, 1, 8'h1E, 8'h40, 0, 8'h1E, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h40, 0, 8'h20, 1, 0, 0);
        add(0, 1, 0, 1, 0, 8'h00, 8'h40, 0, 8'h20, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h40, 0, 8'h20, 0, 0, 0);
        add(0, 1, 0, 1, 0, 8'h00, 8'h40, 0, 8'h20, 0, 0, 0);
        // en=0 holds in RUN; limit change applies on the next compare
        add(0, 1, 1, 0, 0, 8'h00, 8'h40, 0, 8'h00, 1, 0, 0);
        add(0, 0, 0, 0, 0, 8'h00, 8'h40, 0, 8'h00, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h40, 0, 8'h02, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h03, 1, 8'h00, 1, 1, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h03, 1, 8'h02, 1, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            cyc(vq[i].rst, vq[i].en, vq[i].start, vq[i].stop, vq[i].load,
                vq[i].lv, vq[i].lim, vq[i].wrap);
            expect_all("tbl", i, vq[i].eo, vq[i].eb, vq[i].et, vq[i].ed);
        end

        // Zero limit: full-range count to FE, then wrap with tc.
        cyc(1, 0, 0, 0, 0, 8'h00, 8'h00, 1);
        expect_all("lim0_rst", 0, 8'h00, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 8'h00, 8'h00, 1);
        expect_all("lim0_start", 0, 8'h00, 1, 0, 0);
        for (int i = 1; i <= 127; i++) begin
            cyc(0, 1, 0, 0, 0, 8'h00, 8'h00, 1);
            chk("lim0.out", i, out, 8'(2 * i));
            chk("lim0.tc", i, {7'd0, tc}, 8'h00);
        end
        cyc(0, 1, 0, 0, 0, 8'h00, 8'h00, 1);
        expect_all("lim0_wrap", 128, 8'h00, 1, 1, 0);
        cyc(0, 1, 0, 0, 0, 8'h00, 8'h00, 1);
        expect_all("lim0_after", 129, 8'h02, 1, 0, 0);

        // Reset on the edge that would pulse done (w=0) or tc (w=1).
        for (int w = 0; w < 2; w++) begin
            cyc(1, 0, 0, 0, 0, 8'h00, 8'h04, w[0]);
            cyc(0, 1, 1, 0, 0, 8'h00, 8'h04, w[0]);
            cyc(0, 1, 0, 0, 0, 8'h00, 8'h04, w[0]);
            cyc(0, 1, 0, 0, 0, 8'h00, 8'h04, w[0]);
            expect_all("rstterm_pre", w, 8'h04, 1, 0, 0);
            cyc(1, 1, 0, 0, 0, 8'h00, 8'h04, w[0]);
            expect_all("rstterm_rst", w, 8'h00, 0, 0, 0);
            cyc(0, 1, 0, 0, 0, 8'h00, 8'h04, w[0]);
            expect_all("rstterm_idle1", w, 8'h00, 0, 0, 0);
            cyc(0, 1, 0, 0, 0, 8'h00, 8'h04, w[0]);
            expect_all("rstterm_idle2", w, 8'h00, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
